// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: acknowledges each received byte once,
// stores it in a first-word-fall-through FIFO and raises status flags and an interrupt.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_irq_i,
    input  logic [7:0]    rx_data_i,
    output logic          rx_read_o,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i,
    input  logic          irq_en_i,
    output logic          irq_o
);

    typedef enum logic {StIdle, StAck} state_e;

    state_e        state_q;
    logic          rx_read_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_q;
    logic [7:0]    mem_q [DEPTH];

    logic capture, push, drop, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A full FIFO still has room when the head is popped on the same edge.
    assign capture = (state_q == StIdle) & rx_irq_i;
    assign pop_ok  = pop_i & ~empty_o;
    assign push    = capture & (~full_o | pop_i);
    assign drop    = capture & full_o & ~pop_i;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_ok);
        ovf_d    = drop | (ovf_q & ~clr_ovf_i);
    end

    // ACK waits for the receiver to drop irq so one byte is never taken twice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rx_read_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rx_read_q <= rx_irq_i;
                    if (rx_irq_i) state_q <= StAck;
                end
                StAck: begin
                    rx_read_q <= 1'b0;
                    if (!rx_irq_i) state_q <= StIdle;
                end
                default: begin
                    rx_read_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_en_i & ~empty_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rx_data_i;
    end

    assign dout_o     = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_read_o  = rx_read_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign irq_o      = irq_q;

endmodule
